alu_issue_arbiter: RTL
======================

# alu_issue_arbiter

Shares the single EXE-stage `ALU` datapath between two issue requesters: slot 0 (primary pipe) and slot 1 (secondary pipe). Each slot presents operands and a one-hot ALU opcode on a valid/ready channel. A two-way round-robin arbiter grants at most one request per cycle. The combinational ALU result and overflow are captured in a per-slot output register, each drained by its own valid/ready result channel.

## Interface
- `DATA_W`, default 32: operand/result width; must match `SINGLE_WORD`.
- `OP_W`, default 12: one-hot ALU opcode width; must match `ALUOP`.
- `TAG_W`, default 4: opaque requester tag, carried unchanged to the result.
- `CNT_W`, default 16: width of the contention counter.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  slot N (N=0,1) request valid.
- `reqN_ready`  out  1  slot N granted this cycle.
- `reqN_src0`  in  DATA_W  ALU operand 0; shift amount is in [4:0].
- `reqN_src1`  in  DATA_W  ALU operand 1.
- `reqN_aluop`  in  OP_W  one-hot opcode.
- `reqN_tag`  in  TAG_W  requester tag.
- `resN_valid`  out  1  slot N result held.
- `resN_ready`  in  1  slot N consumer accepts the result.
- `resN_data`  out  DATA_W  registered ALU result.
- `resN_ov`  out  1  registered overflow; meaningful only for add/sub.
- `resN_tag`  out  TAG_W  tag of the producing request.
- `resN_err`  out  1  opcode was not exactly one-hot.
- `conflict_cnt`  out  CNT_W  saturating count of contention stall cycles.

## Operation
- Eligibility: `elig_N = reqN_valid && (!resN_valid || resN_ready)`. A slot is never granted while its result register is full and not draining.
- Arbitration uses a priority pointer `prio`. If only one slot is eligible, it is granted. If both are eligible, slot `prio` is granted.
- On any grant to slot i, `prio <= ~i`.
- `reqN_ready` equals the grant for slot N. It is combinational from `reqN_valid`, `resN_valid`, `resN_ready` and `prio`, and never depends on `reqN_aluop` or the operands.
- The granted slot's src0, src1 and aluop are muxed into the single `ALU` instance.
- On a handshake (`reqN_valid && reqN_ready`), the slot N result register loads:
  - `resN_data` from ALU `aluso`;
  - `resN_ov` from ALU `overflow`, gated by the add or sub opcode bit;
  - `resN_tag`;
  - `resN_err` = (popcount(aluop) != 1).
- When `resN_err` is set, `resN_data` = 0 and `resN_ov` = 0.
- `resN_valid`:
  - set by a load;
  - cleared by `resN_ready` when no simultaneous load occurs;
  - a simultaneous drain and load keeps it at 1 with the new contents.
- The result register holds its contents stable while `resN_valid && !resN_ready`.
- `conflict_cnt` increments in any cycle where both `reqN_valid` are 1 and only one is granted. It saturates at all-ones.
- The ungranted requester must hold its request stable until granted; the block does not check this.

## Timing
- Reset values (async on `resetn` low): `resN_valid` = 0, `resN_data` = 0, `resN_ov` = 0, `resN_tag` = 0, `resN_err` = 0, `prio` = 0, `conflict_cnt` = 0.
- `reqN_ready` is 0 whenever `resetn` is low.
- Reset asserted mid-operation discards any held results. Requests in flight are lost, and requesters re-present after reset.
- Latency is 1 cycle: a handshake at edge k produces `resN_valid` = 1 after edge k.
- Throughput:
  - a single active slot with its consumer always ready sustains 1 op/cycle;
  - both slots continuously valid alternate 0,1,0,1… once contended.
- A blocked slot (result full and not draining) does not consume a turn. The other slot is granted every cycle and `prio` still flips per grant.

## Structure
- Add to the shared defines header: `TAG_W`, `CNT_W` defaults and an `ARB_SLOTS=2` constant. `SINGLE_WORD`, `ALUOP` and the `ALU_*` bit indices are reused unchanged.
- Sub-module `rr_arb2`: inputs elig[1:0]; output grant[1:0] (one-hot or zero); owns `prio`.
- `ALU` is instantiated once, unchanged.
- Per-slot result registers and the counter are inline in the top.

## Test plan
- Slot 0 only, add 0x7FFFFFFF + 0x00000001, `res0_ready`=1 → one cycle later `res0_data`=0x80000000, `res0_ov`=1, tag echoed; `res1_valid` stays 0.
- Both valid from reset, slot 0 sub 5−3 and slot 1 sll with src0=4, src1=1 → slot 0 granted first, `res0_data`=2; slot 1 granted next cycle, `res1_data`=0x10; `conflict_cnt`=1.
- `res0_ready`=0 with `res0_valid`=1 and slot 0 requesting → `req0_ready`=0 and `res0_*` stable for 5 cycles; slot 1 granted every cycle meanwhile; raise `res0_ready` → slot 0 granted the same cycle.
- aluop=0 on slot 1, then aluop with the add and or bits both set → `res1_err`=1, `res1_data`=0, `res1_ov`=0 for both.
- Both slots continuously valid for 2^CNT_W + 3 cycles with consumers ready → grants strictly alternate and `conflict_cnt` saturates at 0xFFFF.
- Assert `resetn`=0 asynchronously mid-cycle while `res0_valid`=1 → all `resN_valid` = 0 immediately, `prio` = 0, `conflict_cnt` = 0; after release the first contended grant goes to slot 0.

Source files
------------

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared defines for the EXE-stage ALU and its two-slot issue arbiter.
// Word/opcode widths and ALU_* opcode bit indices are reused by ALU and the arbiter top.
package alu_issue_arbiter_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int ALUOP       = 12;

    localparam int ARB_TAG_W = 4;
    localparam int ARB_CNT_W = 16;
    localparam int ARB_SLOTS = 2;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef enum logic {
        SLOT0 = 1'b0,
        SLOT1 = 1'b1
    } slot_e;

    function automatic logic onehot_ok(input logic [ALUOP-1:0] op);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < ALUOP; i++) begin
            ones = ones + int'(op[i]);
        end
        return ones == 1;
    endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// One issue slot: request channel into the shared ALU plus its result channel.
// master = requester/consumer side, slave = arbiter side.
interface alu_issue_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 12,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_src0;
    logic [DATA_W-1:0] req_src1;
    logic [OP_W-1:0]   req_aluop;
    logic [TAG_W-1:0]  req_tag;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_ov;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;

    modport master (
        output req_valid, req_src0, req_src1, req_aluop, req_tag, res_ready,
        input  req_ready, res_valid, res_data, res_ov, res_tag, res_err
    );

    modport slave (
        input  req_valid, req_src0, req_src1, req_aluop, req_tag, res_ready,
        output req_ready, res_valid, res_data, res_ov, res_tag, res_err
    );
endinterface

// File: rtl/ALU.sv
// Combinational EXE-stage ALU with a one-hot opcode; shift amount comes from alu_src0[4:0].
// overflow reports signed overflow for add and sub only.
module ALU
    import alu_issue_arbiter_pkg::*;
(
    input  logic [ALUOP-1:0]       aluop,
    input  logic [SINGLE_WORD-1:0] alu_src0,
    input  logic [SINGLE_WORD-1:0] alu_src1,
    output logic [SINGLE_WORD-1:0] aluso,
    output logic                   overflow
);
    localparam int MSB = SINGLE_WORD - 1;

    logic [SINGLE_WORD-1:0] sum;
    logic [SINGLE_WORD-1:0] diff;
    logic [4:0]             sa;

    always_comb begin
        sum  = alu_src0 + alu_src1;
        diff = alu_src0 - alu_src1;
        sa   = alu_src0[4:0];

        aluso = '0;
        if (aluop[ALU_ADD])  aluso = aluso | sum;
        if (aluop[ALU_SUB])  aluso = aluso | diff;
        if (aluop[ALU_SLT])  aluso = aluso | {{MSB{1'b0}}, $signed(alu_src0) < $signed(alu_src1)};
        if (aluop[ALU_SLTU]) aluso = aluso | {{MSB{1'b0}}, alu_src0 < alu_src1};
        if (aluop[ALU_AND])  aluso = aluso | (alu_src0 & alu_src1);
        if (aluop[ALU_NOR])  aluso = aluso | ~(alu_src0 | alu_src1);
        if (aluop[ALU_OR])   aluso = aluso | (alu_src0 | alu_src1);
        if (aluop[ALU_XOR])  aluso = aluso | (alu_src0 ^ alu_src1);
        if (aluop[ALU_SLL])  aluso = aluso | (alu_src1 << sa);
        if (aluop[ALU_SRL])  aluso = aluso | (alu_src1 >> sa);
        if (aluop[ALU_SRA])  aluso = aluso | $unsigned($signed(alu_src1) >>> sa);
        if (aluop[ALU_LUI])  aluso = aluso | {alu_src1[15:0], 16'h0000};

        overflow = (aluop[ALU_ADD] && (alu_src0[MSB] == alu_src1[MSB]) && (sum[MSB]  != alu_src0[MSB])) ||
                   (aluop[ALU_SUB] && (alu_src0[MSB] != alu_src1[MSB]) && (diff[MSB] != alu_src0[MSB]));
    end
endmodule

// File: rtl/alu_issue_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: single eligible slot wins outright, a tie goes to prio.
// prio points away from the most recent winner.
module rr_arb2
    import alu_issue_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ARB_SLOTS-1:0] elig,
    output logic [ARB_SLOTS-1:0] grant
);
    slot_e prio;

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = (prio == SLOT1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio <= SLOT0;
        end else if (grant[0]) begin
            prio <= SLOT1;
        end else if (grant[1]) begin
            prio <= SLOT0;
        end
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between two issue slots; each slot owns a one-deep result register
// drained by its own valid/ready channel, plus a saturating contention counter.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int DATA_W = SINGLE_WORD,
    parameter int OP_W   = ALUOP,
    parameter int TAG_W  = ARB_TAG_W,
    parameter int CNT_W  = ARB_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    alu_issue_arbiter_if.slave   slot0,
    alu_issue_arbiter_if.slave   slot1,
    output logic [CNT_W-1:0]     conflict_cnt
);
    logic [ARB_SLOTS-1:0] req_valid;
    logic [ARB_SLOTS-1:0] res_ready;
    logic [ARB_SLOTS-1:0] elig;
    logic [ARB_SLOTS-1:0] grant;
    logic [ARB_SLOTS-1:0] op_err;
    logic [ARB_SLOTS-1:0] load_ov;

    logic [DATA_W-1:0] src0  [ARB_SLOTS];
    logic [DATA_W-1:0] src1  [ARB_SLOTS];
    logic [OP_W-1:0]   aluop [ARB_SLOTS];
    logic [TAG_W-1:0]  tag   [ARB_SLOTS];

    logic [ARB_SLOTS-1:0] res_valid_q;
    logic [ARB_SLOTS-1:0] res_ov_q;
    logic [ARB_SLOTS-1:0] res_err_q;
    logic [DATA_W-1:0]    res_data_q [ARB_SLOTS];
    logic [TAG_W-1:0]     res_tag_q  [ARB_SLOTS];

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_src0;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] aluso;
    logic              alu_ov;

    assign req_valid = {slot1.req_valid, slot0.req_valid};
    assign res_ready = {slot1.res_ready, slot0.res_ready};
    assign src0[0]   = slot0.req_src0;
    assign src0[1]   = slot1.req_src0;
    assign src1[0]   = slot0.req_src1;
    assign src1[1]   = slot1.req_src1;
    assign aluop[0]  = slot0.req_aluop;
    assign aluop[1]  = slot1.req_aluop;
    assign tag[0]    = slot0.req_tag;
    assign tag[1]    = slot1.req_tag;

    // Gating with resetn keeps both ready outputs low throughout reset.
    assign elig = req_valid & (~res_valid_q | res_ready) & {ARB_SLOTS{resetn}};

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .elig   (elig),
        .grant  (grant)
    );

    always_comb begin
        alu_op   = grant[1] ? aluop[1] : aluop[0];
        alu_src0 = grant[1] ? src0[1]  : src0[0];
        alu_src1 = grant[1] ? src1[1]  : src1[0];
    end

    ALU u_alu (
        .aluop    (alu_op),
        .alu_src0 (alu_src0),
        .alu_src1 (alu_src1),
        .aluso    (aluso),
        .overflow (alu_ov)
    );

    always_comb begin
        op_err  = '0;
        load_ov = '0;
        for (int unsigned i = 0; i < ARB_SLOTS; i++) begin
            op_err[i]  = !onehot_ok(aluop[i]);
            load_ov[i] = !op_err[i] && alu_ov && (aluop[i][ALU_ADD] || aluop[i][ALU_SUB]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid_q <= '0;
            res_ov_q    <= '0;
            res_err_q   <= '0;
            for (int unsigned i = 0; i < ARB_SLOTS; i++) begin
                res_data_q[i] <= '0;
                res_tag_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ARB_SLOTS; i++) begin
                if (grant[i]) begin
                    res_valid_q[i] <= 1'b1;
                    res_data_q[i]  <= op_err[i] ? '0 : aluso;
                    res_ov_q[i]    <= load_ov[i];
                    res_err_q[i]   <= op_err[i];
                    res_tag_q[i]   <= tag[i];
                end else if (res_ready[i]) begin
                    res_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflict_cnt <= '0;
        end else if ((&req_valid) && (^grant) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign slot0.req_ready = grant[0];
    assign slot1.req_ready = grant[1];
    assign slot0.res_valid = res_valid_q[0];
    assign slot1.res_valid = res_valid_q[1];
    assign slot0.res_data  = res_data_q[0];
    assign slot1.res_data  = res_data_q[1];
    assign slot0.res_ov    = res_ov_q[0];
    assign slot1.res_ov    = res_ov_q[1];
    assign slot0.res_tag   = res_tag_q[0];
    assign slot1.res_tag   = res_tag_q[1];
    assign slot0.res_err   = res_err_q[0];
    assign slot1.res_err   = res_err_q[1];
endmodule
